acp_mm2s_mover: RTL and testbench

- Command-driven memory-to-stream read engine, the responder for the 72-bit command / 8-bit status streams that the stream-master control blocks issue.
- Takes one command, issues AXI4 INCR read bursts on the ACP master port and forwards the read data as a 64-bit AXI stream towards the custom hardware.
- Returns one status byte per command.
- Sits between the h2s control master and the accelerator datapath.

---
 rtl/acp_mm2s_mover.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_acp_mm2s_mover.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acp_mm2s_mover.sv
// acp_mm2s_mover: command-driven memory-to-stream read engine.
// Takes a 72-bit command, issues AXI4 INCR read bursts on the ACP port,
// forwards the read data as a 64-bit AXI stream and returns one status byte.
// Optional build macro ACP_MM2S_SKID_EN inserts a 2-entry registered skid
// buffer between the R channel and the output stream.
module acp_mm2s_mover #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_BURST        = 16,
    parameter logic [2:0]  C_PROT             = 3'b010
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [71:0]                   S_AXIS_CMD_TDATA,
    input  logic                          S_AXIS_CMD_TVALID,
    output logic                          S_AXIS_CMD_TREADY,
    output logic [7:0]                    M_AXIS_STS_TDATA,
    output logic                          M_AXIS_STS_TVALID,
    input  logic                          M_AXIS_STS_TREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY
);

    localparam int unsigned BEATS_W = 20;
    localparam int unsigned LEN_W   = 9;
    localparam int unsigned PAGE_W  = 10;
    localparam int unsigned BTT_W   = 23;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STS   = 3'd4;

    logic [2:0]                    state_q, state_d;
    logic                          cmd_rdy_q, cmd_rdy_d;
    logic [31:0]                   addr_q, addr_d;
    logic [BTT_W-1:0]              btt_q, btt_d;
    logic                          eof_q, eof_d;
    logic [3:0]                    tag_q, tag_d;
    logic [BEATS_W-1:0]            beats_left_q, beats_left_d;
    logic                          interr_q, interr_d;
    logic                          slverr_q, slverr_d;
    logic                          decerr_q, decerr_d;
    logic                          arvalid_q, arvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                    arlen_q, arlen_d;
    logic                          sts_valid_q, sts_valid_d;
    logic [7:0]                    sts_data_q, sts_data_d;

    logic                          in_data_c;
    logic                          rready_c;
    logic                          r_hs_c;
    logic                          last_beat_c;
    logic                          drained_c;
    logic [PAGE_W-1:0]             page_beats_c;
    logic [BEATS_W-1:0]            len_wide_c;
    logic [LEN_W-1:0]              len_c;

    // Command bits outside the decoded fields
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31],
                               S_AXIS_CMD_TDATA[29:23]};

    assign S_AXIS_CMD_TREADY = cmd_rdy_q;
    assign M_AXIS_STS_TDATA  = sts_data_q;
    assign M_AXIS_STS_TVALID = sts_valid_q;
    assign M_AXI_ARADDR      = araddr_q;
    assign M_AXI_ARLEN       = arlen_q;
    assign M_AXI_ARVALID     = arvalid_q;
    assign M_AXI_ARSIZE      = 3'b011;
    assign M_AXI_ARBURST     = 2'b01;
    assign M_AXI_ARCACHE     = 4'b1111;
    assign M_AXI_ARPROT      = C_PROT;

    assign in_data_c   = (state_q == ST_DATA);
    assign r_hs_c      = in_data_c && M_AXI_RVALID && rready_c;
    assign last_beat_c = M_AXI_RLAST && (beats_left_q == '0) && eof_q;
    assign M_AXI_RREADY = rready_c;

    // Burst length: remaining beats, capped by max burst and the 4 KB page end
    always_comb begin
        page_beats_c = PAGE_W'((13'd4096 - {1'b0, addr_q[11:0]}) >> 3);
        len_wide_c   = beats_left_q;
        if (len_wide_c > BEATS_W'(C_MAX_BURST)) begin
            len_wide_c = BEATS_W'(C_MAX_BURST);
        end
        if (len_wide_c > BEATS_W'(page_beats_c)) begin
            len_wide_c = BEATS_W'(page_beats_c);
        end
        len_c = LEN_W'(len_wide_c);
    end

`ifdef ACP_MM2S_SKID_EN
    localparam int unsigned SKID_W = C_M_AXI_DATA_WIDTH + 1;

    logic [SKID_W-1:0] skid_q [2];
    logic [SKID_W-1:0] skid_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop_c;

    assign rready_c      = in_data_c && (cnt_q != 2'd2);
    assign pop_c         = (cnt_q != 2'd0) && M_AXIS_TREADY;
    assign drained_c     = (cnt_q == 2'd0);
    assign M_AXIS_TVALID = (cnt_q != 2'd0);
    assign M_AXIS_TDATA  = skid_q[rd_ptr_q][C_M_AXI_DATA_WIDTH-1:0];
    assign M_AXIS_TLAST  = skid_q[rd_ptr_q][SKID_W-1];

    // Skid buffer push/pop bookkeeping
    always_comb begin
        skid_d   = skid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (r_hs_c) begin
            skid_d[wr_ptr_q] = {last_beat_c, M_AXI_RDATA};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(r_hs_c) - 2'(pop_c);
    end

    // Skid buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            skid_q    <= skid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end
`else
    assign rready_c      = in_data_c && M_AXIS_TREADY;
    assign drained_c     = 1'b1;
    assign M_AXIS_TVALID = in_data_c && M_AXI_RVALID;
    assign M_AXIS_TDATA  = M_AXI_RDATA;
    assign M_AXIS_TLAST  = in_data_c && last_beat_c;
`endif

    // Next-state and datapath update for the command FSM
    always_comb begin
        state_d      = state_q;
        cmd_rdy_d    = cmd_rdy_q;
        addr_d       = addr_q;
        btt_d        = btt_q;
        eof_d        = eof_q;
        tag_d        = tag_q;
        beats_left_d = beats_left_q;
        interr_d     = interr_q;
        slverr_d     = slverr_q;
        decerr_d     = decerr_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        sts_valid_d  = sts_valid_q;
        sts_data_d   = sts_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_rdy_q && S_AXIS_CMD_TVALID) begin
                    addr_d    = S_AXIS_CMD_TDATA[63:32];
                    btt_d     = S_AXIS_CMD_TDATA[22:0];
                    eof_d     = S_AXIS_CMD_TDATA[30];
                    tag_d     = S_AXIS_CMD_TDATA[67:64];
                    cmd_rdy_d = 1'b0;
                    state_d   = ST_CHECK;
                end else begin
                    cmd_rdy_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if ((btt_q == '0) || (addr_q[2:0] != 3'd0) || (btt_q[2:0] != 3'd0)) begin
                    interr_d = 1'b1;
                    state_d  = ST_STS;
                end else begin
                    beats_left_d = btt_q[22:3];
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!arvalid_q) begin
                    arvalid_d = 1'b1;
                    araddr_d  = C_M_AXI_ADDR_WIDTH'(addr_q);
                    arlen_d   = 8'(len_c - 9'd1);
                end else if (M_AXI_ARREADY) begin
                    arvalid_d    = 1'b0;
                    addr_d       = addr_q + 32'({arlen_q, 3'b000}) + 32'd8;
                    beats_left_d = beats_left_q - BEATS_W'(arlen_q) - BEATS_W'(1);
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs_c) begin
                    if (M_AXI_RRESP == 2'b10) slverr_d = 1'b1;
                    if (M_AXI_RRESP == 2'b11) decerr_d = 1'b1;
                    if (M_AXI_RLAST) begin
                        state_d = (beats_left_q != '0) ? ST_ADDR : ST_STS;
                    end
                end
            end
            ST_STS: begin
                if (!sts_valid_q) begin
                    if (drained_c) begin
                        sts_valid_d = 1'b1;
                        sts_data_d  = {~(interr_q | decerr_q | slverr_q),
                                       slverr_q, decerr_q, interr_q, tag_q};
                    end
                end else if (M_AXIS_STS_TREADY) begin
                    sts_valid_d = 1'b0;
                    interr_d    = 1'b0;
                    slverr_d    = 1'b0;
                    decerr_d    = 1'b0;
                    cmd_rdy_d   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_rdy_q    <= 1'b0;
            addr_q       <= '0;
            btt_q        <= '0;
            eof_q        <= 1'b0;
            tag_q        <= '0;
            beats_left_q <= '0;
            interr_q     <= 1'b0;
            slverr_q     <= 1'b0;
            decerr_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            sts_valid_q  <= 1'b0;
            sts_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_rdy_q    <= cmd_rdy_d;
            addr_q       <= addr_d;
            btt_q        <= btt_d;
            eof_q        <= eof_d;
            tag_q        <= tag_d;
            beats_left_q <= beats_left_d;
            interr_q     <= interr_d;
            slverr_q     <= slverr_d;
            decerr_q     <= decerr_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            sts_valid_q  <= sts_valid_d;
            sts_data_q   <= sts_data_d;
        end
    end

endmodule

// File: tb/tb_acp_mm2s_mover.sv
// Bench for acp_mm2s_mover: table of commands with hand-computed expected
// bursts, beat counts and status, a reset-value check and a mid-burst reset.
module tb_acp_mm2s_mover;

    logic        clk;
    logic        rst_n;
    logic [71:0] S_AXIS_CMD_TDATA;
    logic        S_AXIS_CMD_TVALID;
    logic        S_AXIS_CMD_TREADY;
    logic [7:0]  M_AXIS_STS_TDATA;
    logic        M_AXIS_STS_TVALID;
    logic        M_AXIS_STS_TREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [63:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [63:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;

    acp_mm2s_mover dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .S_AXIS_CMD_TDATA  (S_AXIS_CMD_TDATA),
        .S_AXIS_CMD_TVALID (S_AXIS_CMD_TVALID),
        .S_AXIS_CMD_TREADY (S_AXIS_CMD_TREADY),
        .M_AXIS_STS_TDATA  (M_AXIS_STS_TDATA),
        .M_AXIS_STS_TVALID (M_AXIS_STS_TVALID),
        .M_AXIS_STS_TREADY (M_AXIS_STS_TREADY),
        .M_AXI_ARADDR      (M_AXI_ARADDR),
        .M_AXI_ARLEN       (M_AXI_ARLEN),
        .M_AXI_ARSIZE      (M_AXI_ARSIZE),
        .M_AXI_ARBURST     (M_AXI_ARBURST),
        .M_AXI_ARCACHE     (M_AXI_ARCACHE),
        .M_AXI_ARPROT      (M_AXI_ARPROT),
        .M_AXI_ARVALID     (M_AXI_ARVALID),
        .M_AXI_ARREADY     (M_AXI_ARREADY),
        .M_AXI_RDATA       (M_AXI_RDATA),
        .M_AXI_RRESP       (M_AXI_RRESP),
        .M_AXI_RLAST       (M_AXI_RLAST),
        .M_AXI_RVALID      (M_AXI_RVALID),
        .M_AXI_RREADY      (M_AXI_RREADY),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TREADY     (M_AXIS_TREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] saddr;
        logic [22:0] btt;
        bit          eof;
        logic [3:0]  tag;
        bit          stall;
        int          err_beat;
        logic [1:0]  err_resp;
        logic [7:0]  exp_sts;
        int          exp_nar;
        logic [31:0] ar0_a;
        logic [7:0]  ar0_l;
        logic [31:0] ar1_a;
        logic [7:0]  ar1_l;
        int          exp_beats;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Logs filled by the bus process
    logic [31:0] ar_log_addr[$];
    logic [7:0]  ar_log_len[$];
    logic [63:0] beat_data[$];
    logic        beat_last[$];
    logic [7:0]  sts_log[$];
    int          overlap_err = 0;
    int          stab_err    = 0;
    bit          stall_en    = 1'b0;
    int          err_beat    = -1;
    logic [1:0]  err_resp    = 2'b00;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI read slave, stream sink and status sink: sample at negedge, drive at posedge+1
    initial begin : bus
        bit          have_burst;
        logic [31:0] b_addr;
        int          b_left;
        int          beat_idx;
        bit          ar_hs, r_hs, s_hs, st_hs;
        bit          ar_wait;
        logic [31:0] ar_wait_addr;
        logic [7:0]  ar_wait_len;
        have_burst = 0; b_addr = '0; b_left = 0; beat_idx = 0; ar_wait = 0;
        ar_wait_addr = '0; ar_wait_len = '0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
        M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
        M_AXIS_TREADY = 1'b0; M_AXIS_STS_TREADY = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs  = M_AXI_RVALID && M_AXI_RREADY;
            s_hs  = M_AXIS_TVALID && M_AXIS_TREADY;
            st_hs = M_AXIS_STS_TVALID && M_AXIS_STS_TREADY;
            if (ar_wait && !(M_AXI_ARVALID && M_AXI_ARADDR == ar_wait_addr &&
                             M_AXI_ARLEN == ar_wait_len)) stab_err++;
            ar_wait      = M_AXI_ARVALID && !M_AXI_ARREADY;
            ar_wait_addr = M_AXI_ARADDR;
            ar_wait_len  = M_AXI_ARLEN;
            if (ar_hs) begin
                if (have_burst) overlap_err++;
                ar_log_addr.push_back(M_AXI_ARADDR);
                ar_log_len.push_back(M_AXI_ARLEN);
                have_burst = 1;
                b_addr     = M_AXI_ARADDR;
                b_left     = int'(M_AXI_ARLEN) + 1;
            end else if (r_hs) begin
                b_addr = b_addr + 32'd8;
                b_left--;
                beat_idx++;
                if (b_left == 0) have_burst = 0;
            end
            if (s_hs) begin
                beat_data.push_back(M_AXIS_TDATA);
                beat_last.push_back(M_AXIS_TLAST);
            end
            if (st_hs) begin
                sts_log.push_back(M_AXIS_STS_TDATA);
                beat_idx = 0;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                have_burst = 0; beat_idx = 0; ar_wait = 0;
            end
            M_AXI_ARREADY     = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
            M_AXIS_TREADY     = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            M_AXIS_STS_TREADY = stall_en ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (!have_burst) begin
                M_AXI_RVALID = 1'b0;
                M_AXI_RLAST  = 1'b0;
            end else if (!(M_AXI_RVALID && !r_hs)) begin
                M_AXI_RVALID = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                M_AXI_RDATA  = mem_word(b_addr);
                M_AXI_RLAST  = (b_left == 1);
                M_AXI_RRESP  = (beat_idx == err_beat) ? err_resp : 2'b00;
            end
        end
    end

    task automatic send_cmd(input vec_t v, output bit ok);
        ar_log_addr.delete(); ar_log_len.delete();
        beat_data.delete(); beat_last.delete(); sts_log.delete();
        stall_en = v.stall;
        err_beat = v.err_beat;
        err_resp = v.err_resp;
        ok = 0;
        @(posedge clk); #2;
        S_AXIS_CMD_TDATA  = {4'hF, v.tag, v.saddr, 1'b1, v.eof, 7'h55, v.btt};
        S_AXIS_CMD_TVALID = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (S_AXIS_CMD_TREADY) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #2;
        S_AXIS_CMD_TVALID = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input string name);
        bit          ok;
        bit          done;
        int          bad_data, bad_last, geo_bad, sum;
        logic [31:0] nxt;
        send_cmd(v, ok);
        chk({name, " cmd accepted"}, 64'(ok), 64'd1);
        done = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (sts_log.size() > 0) begin
                done = 1;
                break;
            end
        end
        chk({name, " status in time"}, 64'(done), 64'd1);
        chk({name, " sts"}, (sts_log.size() > 0) ? 64'(sts_log[0]) : 64'hDEAD, 64'(v.exp_sts));
        chk({name, " ar count"}, 64'(ar_log_addr.size()), 64'(v.exp_nar));
        if (v.exp_nar > 0 && ar_log_addr.size() > 0) begin
            chk({name, " ar0 addr"}, 64'(ar_log_addr[0]), 64'(v.ar0_a));
            chk({name, " ar0 len"}, 64'(ar_log_len[0]), 64'(v.ar0_l));
        end
        if (v.exp_nar > 1 && ar_log_addr.size() > 1) begin
            chk({name, " ar1 addr"}, 64'(ar_log_addr[1]), 64'(v.ar1_a));
            chk({name, " ar1 len"}, 64'(ar_log_len[1]), 64'(v.ar1_l));
        end
        chk({name, " beats"}, 64'(beat_data.size()), 64'(v.exp_beats));
        bad_data = 0;
        bad_last = 0;
        for (int k = 0; k < beat_data.size(); k++) begin
            if (beat_data[k] !== mem_word(v.saddr + 32'(k * 8))) bad_data++;
            if (beat_last[k] !== (v.eof && k == v.exp_beats - 1)) bad_last++;
        end
        if (v.exp_beats > 0) begin
            chk({name, " data errors"}, 64'(bad_data), 64'd0);
            chk({name, " tlast errors"}, 64'(bad_last), 64'd0);
        end
        geo_bad = 0;
        sum     = 0;
        nxt     = v.saddr;
        for (int j = 0; j < ar_log_addr.size(); j++) begin
            int bl;
            bl  = int'(ar_log_len[j]) + 1;
            sum += bl;
            if (int'(ar_log_addr[j][11:0]) + bl * 8 > 4096) geo_bad++;
            if (bl > 16) geo_bad++;
            if (ar_log_addr[j] != nxt) geo_bad++;
            nxt = ar_log_addr[j] + 32'(bl * 8);
        end
        if (sum != v.exp_beats) geo_bad++;
        chk({name, " burst geometry"}, 64'(geo_bad), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[9];

    initial begin : main
        bit ok;
        bit mid;
        vecs[0] = '{32'h0000_1000, 23'h80,   1'b1, 4'h5, 1'b0, -1, 2'b00, 8'h85,  1, 32'h0000_1000, 8'd15, 32'h0,          8'd0,  16};
        vecs[1] = '{32'h0000_0FF0, 23'h40,   1'b1, 4'h1, 1'b0, -1, 2'b00, 8'h81,  2, 32'h0000_0FF0, 8'd1,  32'h0000_1000, 8'd5,   8};
        vecs[2] = '{32'h0000_2004, 23'h10,   1'b1, 4'h3, 1'b0, -1, 2'b00, 8'h13,  0, 32'h0,          8'd0,  32'h0,          8'd0,   0};
        vecs[3] = '{32'h0000_3000, 23'h0,    1'b1, 4'h3, 1'b0, -1, 2'b00, 8'h13,  0, 32'h0,          8'd0,  32'h0,          8'd0,   0};
        vecs[4] = '{32'h0000_4000, 23'h20,   1'b0, 4'h6, 1'b0,  1, 2'b10, 8'h46,  1, 32'h0000_4000, 8'd3,  32'h0,          8'd0,   4};
        vecs[5] = '{32'h0000_8000, 23'h1000, 1'b1, 4'hA, 1'b1, -1, 2'b00, 8'h8A, 32, 32'h0000_8000, 8'd15, 32'h0000_8080, 8'd15, 512};
        vecs[6] = '{32'h0000_1000, 23'h0C,   1'b1, 4'h2, 1'b0, -1, 2'b00, 8'h12,  0, 32'h0,          8'd0,  32'h0,          8'd0,   0};
        vecs[7] = '{32'hFFFF_FFF0, 23'h20,   1'b1, 4'h7, 1'b0, -1, 2'b00, 8'h87,  2, 32'hFFFF_FFF0, 8'd1,  32'h0000_0000, 8'd1,   4};
        vecs[8] = '{32'h0000_5000, 23'h18,   1'b1, 4'h9, 1'b0,  2, 2'b11, 8'h29,  1, 32'h0000_5000, 8'd2,  32'h0,          8'd0,   3};

        rst_n = 1'b0;
        S_AXIS_CMD_TDATA  = '0;
        S_AXIS_CMD_TVALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset cmd_tready", 64'(S_AXIS_CMD_TREADY), 64'd0);
        chk("reset arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("reset araddr", 64'(M_AXI_ARADDR), 64'd0);
        chk("reset arlen", 64'(M_AXI_ARLEN), 64'd0);
        chk("reset sts_tvalid", 64'(M_AXIS_STS_TVALID), 64'd0);
        chk("reset sts_tdata", 64'(M_AXIS_STS_TDATA), 64'd0);
        chk("reset m_axis_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("reset rready", 64'(M_AXI_RREADY), 64'd0);
        chk("ar constants", 64'({M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARPROT}),
            64'({3'b011, 2'b01, 4'b1111, 3'b010}));
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_tready after reset", 64'(S_AXIS_CMD_TREADY), 64'd1);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of a data burst
        send_cmd('{32'h0000_6000, 23'h100, 1'b1, 4'h4, 1'b0, -1, 2'b00, 8'h84,
                   2, 32'h6000, 8'd15, 32'h6080, 8'd15, 32}, ok);
        chk("mid reset cmd accepted", 64'(ok), 64'd1);
        mid = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (beat_data.size() >= 5) begin
                mid = 1;
                break;
            end
        end
        chk("mid reset reached data", 64'(mid), 64'd1);
        chk("pre-reset tvalid", 64'(M_AXIS_TVALID), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("rst arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("rst sts_tvalid", 64'(M_AXIS_STS_TVALID), 64'd0);
        chk("rst rready", 64'(M_AXI_RREADY), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_tready after mid reset", 64'(S_AXIS_CMD_TREADY), 64'd1);
        run_cmd(vecs[0], "post-reset");

        chk("overlapping bursts", 64'(overlap_err), 64'd0);
        chk("ar stable while stalled", 64'(stab_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
